// File: rtl/d_fetch_queue_if.sv
// Fetch-to-decode bundle interface: fetch push side, decode control, registered D outputs.
interface d_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int VAL_W = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             f_valid;
  logic [3:0]       f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [VAL_W-1:0] f_valC, f_valP;
  logic             f_ready;
  logic             D_stall, D_bubble;
  logic [3:0]       D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [VAL_W-1:0] D_valC, D_valP;
  logic             D_valid;
  logic [CW-1:0]    count;

  modport master (
    output f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output D_stall, D_bubble,
    input  f_ready, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_valid, count
  );

  modport slave (
    input  f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  D_stall, D_bubble,
    output f_ready, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_valid, count
  );
endinterface

// File: rtl/d_fetch_queue.sv
// Decode register fronted by a DEPTH-entry FIFO so fetch can run ahead of a stalled decode.
// Stall holds D; bubble loads a nop and discards every queued (wrong-path) bundle.
module d_fetch_queue #(
  parameter int         DEPTH     = 4,
  parameter int         VAL_W     = 64,
  parameter logic [3:0] STAT_AOK  = 4'b1000,
  parameter logic [3:0] ICODE_NOP = 4'b0001
) (
  input logic           clk,
  input logic           rst_n,
  d_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [VAL_W-1:0] valC;
    logic [VAL_W-1:0] valP;
  } bundle_t;

  localparam bundle_t NOP = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: '0, rA: '0,
                              rB: '0, valC: '0, valP: '0};

  bundle_t       mem_q [DEPTH];
  bundle_t       d_q, d_d, f_b;
  logic          dv_q, dv_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, wr_en;

  assign f_b  = '{stat: bus.f_stat, icode: bus.f_icode, ifun: bus.f_ifun, rA: bus.f_rA,
                  rB: bus.f_rB, valC: bus.f_valC, valP: bus.f_valP};
  // Readiness looks at occupancy only: a full queue never borrows the slot freed by a same-cycle pop.
  assign bus.f_ready = (cnt_q < CW'(DEPTH));
  assign push        = bus.f_valid && bus.f_ready;

  always_comb begin
    d_d   = d_q;
    dv_d  = dv_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    wr_en = 1'b0;
    if (bus.D_stall) begin
      if (push) begin
        wr_en = 1'b1;
        wp_d  = wp_q + PW'(1);
        cnt_d = cnt_q + CW'(1);
      end
    end else if (bus.D_bubble) begin
      d_d   = NOP;
      dv_d  = 1'b0;
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end else if (cnt_q != '0) begin
      d_d   = mem_q[rp_q];
      dv_d  = 1'b1;
      rp_d  = rp_q + PW'(1);
      cnt_d = cnt_q - CW'(1) + CW'(push);
      if (push) begin
        wr_en = 1'b1;
        wp_d  = wp_q + PW'(1);
      end
    end else if (push) begin
      // Empty queue: bypass straight into D, same latency as a plain pipeline register.
      d_d  = f_b;
      dv_d = 1'b1;
    end else begin
      d_d  = NOP;
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= NOP;
      dv_q  <= 1'b0;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      d_q   <= d_d;
      dv_q  <= dv_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  // Storage needs no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= f_b;
  end

  assign bus.D_stat  = d_q.stat;
  assign bus.D_icode = d_q.icode;
  assign bus.D_ifun  = d_q.ifun;
  assign bus.D_rA    = d_q.rA;
  assign bus.D_rB    = d_q.rB;
  assign bus.D_valC  = d_q.valC;
  assign bus.D_valP  = d_q.valP;
  assign bus.D_valid = dv_q;
  assign bus.count   = cnt_q;
endmodule

// File: tb/tb_d_fetch_queue.sv
// Directed bench for d_fetch_queue: bypass, fill under stall, drain order, flush, stall+bubble, reset.
module tb_d_fetch_queue;
  localparam int DEPTH = 4;
  localparam int VAL_W = 64;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  d_fetch_queue_if #(.DEPTH(DEPTH), .VAL_W(VAL_W)) bus ();

  d_fetch_queue #(.DEPTH(DEPTH), .VAL_W(VAL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Field values derived from icode so each bundle is distinguishable.
  task automatic drive_f(input logic v, input logic [3:0] ic);
    bus.f_valid = v;
    bus.f_stat  = 4'h8;
    bus.f_icode = ic;
    bus.f_ifun  = ic ^ 4'h1;
    bus.f_rA    = ic;
    bus.f_rB    = 4'hF - ic;
    bus.f_valC  = 64'(ic) << 4;
    bus.f_valP  = 64'(ic) + 64'd1;
  endtask

  task automatic expect_d(input string tag, input logic [3:0] ic, input logic v, input int cnt);
    check({tag, ".icode"}, 64'(bus.D_icode), 64'(ic));
    check({tag, ".valid"}, 64'(bus.D_valid), 64'(v));
    check({tag, ".count"}, 64'(bus.count), 64'(cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    drive_f(1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.stat", 64'(bus.D_stat), 64'h8);
    expect_d("rst", 4'h1, 1'b0, 0);
    check("rst.ready", 64'(bus.f_ready), 64'h1);
    rst_n = 1'b1;

    // Bypass on empty queue
    drive_f(1'b1, 4'h6);
    cyc();
    expect_d("byp", 4'h6, 1'b1, 0);
    check("byp.valC", bus.D_valC, 64'h60);
    check("byp.valP", bus.D_valP, 64'h7);
    check("byp.rB", 64'(bus.D_rB), 64'h9);

    // Fill under stall; fifth bundle rejected
    bus.D_stall = 1'b1;
    drive_f(1'b1, 4'h2); cyc();
    drive_f(1'b1, 4'h3); cyc();
    drive_f(1'b1, 4'h4); cyc();
    drive_f(1'b1, 4'h5); cyc();
    check("fill.count4", 64'(bus.count), 64'd4);
    check("fill.ready0", 64'(bus.f_ready), 64'h0);
    drive_f(1'b1, 4'h7); cyc();
    expect_d("fill.hold", 4'h6, 1'b1, 4);

    // Drain in order, then bubble
    bus.D_stall = 1'b0;
    drive_f(1'b0, 4'h0);
    cyc(); expect_d("drain0", 4'h2, 1'b1, 3);
    check("drain0.valC", bus.D_valC, 64'h20);
    cyc(); expect_d("drain1", 4'h3, 1'b1, 2);
    cyc(); expect_d("drain2", 4'h4, 1'b1, 1);
    cyc(); expect_d("drain3", 4'h5, 1'b1, 0);
    check("drain3.ifun", 64'(bus.D_ifun), 64'h4);
    cyc(); expect_d("drain.empty", 4'h1, 1'b0, 0);

    // Flush: count=3 then bubble with a concurrent push
    bus.D_stall = 1'b1;
    drive_f(1'b1, 4'hA); cyc();
    drive_f(1'b1, 4'hB); cyc();
    drive_f(1'b1, 4'hC); cyc();
    check("flush.pre", 64'(bus.count), 64'd3);
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b1;
    drive_f(1'b1, 4'hD); cyc();
    expect_d("flush", 4'h1, 1'b0, 0);
    check("flush.stat", 64'(bus.D_stat), 64'h8);
    check("flush.valC", bus.D_valC, 64'h0);
    bus.D_bubble = 1'b0;
    drive_f(1'b0, 4'h0); cyc();
    expect_d("flush.absent", 4'h1, 1'b0, 0);

    // Stall+bubble together: stall wins, no flush
    drive_f(1'b1, 4'h9); cyc();
    expect_d("sb.byp", 4'h9, 1'b1, 0);
    bus.D_stall = 1'b1;
    drive_f(1'b1, 4'h2); cyc();
    drive_f(1'b1, 4'h3); cyc();
    bus.D_bubble = 1'b1;
    drive_f(1'b1, 4'h4); cyc();
    expect_d("sb.push", 4'h9, 1'b1, 3);
    drive_f(1'b0, 4'h0); cyc();
    expect_d("sb.hold", 4'h9, 1'b1, 3);

    // Release with concurrent pop+push
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    drive_f(1'b1, 4'h5); cyc();
    expect_d("pp0", 4'h2, 1'b1, 3);
    drive_f(1'b0, 4'h0);
    cyc(); expect_d("pp1", 4'h3, 1'b1, 2);
    cyc(); expect_d("pp2", 4'h4, 1'b1, 1);
    cyc(); expect_d("pp3", 4'h5, 1'b1, 0);
    cyc(); expect_d("pp.empty", 4'h1, 1'b0, 0);

    // Full queue rejects push even while popping
    bus.D_stall = 1'b1;
    drive_f(1'b1, 4'h2); cyc();
    drive_f(1'b1, 4'h3); cyc();
    drive_f(1'b1, 4'h4); cyc();
    drive_f(1'b1, 4'h5); cyc();
    bus.D_stall = 1'b0;
    drive_f(1'b1, 4'hE); cyc();
    expect_d("full.pop", 4'h2, 1'b1, 3);
    drive_f(1'b0, 4'h0);
    cyc(); cyc(); cyc();
    expect_d("full.last", 4'h5, 1'b1, 0);
    cyc(); expect_d("full.noE", 4'h1, 1'b0, 0);

    // Asynchronous reset mid-cycle with count=3
    bus.D_stall = 1'b1;
    drive_f(1'b1, 4'hA); cyc();
    drive_f(1'b1, 4'hB); cyc();
    drive_f(1'b1, 4'hC); cyc();
    check("arst.pre", 64'(bus.count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    expect_d("arst", 4'h1, 1'b0, 0);
    check("arst.stat", 64'(bus.D_stat), 64'h8);
    check("arst.ready", 64'(bus.f_ready), 64'h1);
    bus.D_stall = 1'b0;
    drive_f(1'b1, 4'h6);
    #3 rst_n = 1'b1;
    cyc();
    expect_d("arst.byp", 4'h6, 1'b1, 0);
    drive_f(1'b0, 4'h0);
    cyc();
    expect_d("arst.empty", 4'h1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/d_fetch_queue.md
Name: d_fetch_queue

Overview:
- Parametrised successor to the single-entry decode pipeline register in the Y86-64 pipelined processor.
- Sits between the fetch stage and the D-stage outputs. Holds up to DEPTH fetched instruction bundles in a FIFO so fetch can run ahead while decode is stalled.
- Keeps the stall/bubble semantics of the decode register: stall holds D, bubble injects a nop and flushes all queued wrong-path instructions.
- With an empty queue and no stall it behaves exactly as a one-cycle D register.

Parameters:
DEPTH, 4, queue entries excluding the D output register; power of two, >= 2
VAL_W, 64, width of valC/valP
STAT_AOK, 4'b1000, stat value loaded with a bubble and at reset
ICODE_NOP, 4'b0001, icode loaded with a bubble and at reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
f_valid  input  1  fetch presents a bundle this cycle
f_stat, f_icode, f_ifun, f_rA, f_rB  input  4 each  fetched fields
f_valC, f_valP  input  VAL_W each  fetched constant / next PC
f_ready  output  1  queue can accept a bundle; equals (count < DEPTH)
D_stall  input  1  hold D outputs and do not pop
D_bubble  input  1  load nop into D and flush the queue
D_stat, D_icode, D_ifun, D_rA, D_rB  output  4 each  registered decode fields
D_valC, D_valP  output  VAL_W each  registered decode values
D_valid  output  1  D holds a real instruction (0 = bubble/reset nop)
count  output  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset (rst_n=0, immediate, independent of clk):
  - D_stat=STAT_AOK, D_icode=ICODE_NOP; D_ifun, D_rA, D_rB, D_valC, D_valP = 0.
  - D_valid=0, count=0, read/write pointers = 0.
  - Reset mid-operation discards all queued entries.
- A push is accepted when f_valid && f_ready. f_ready depends on count only; there is no same-cycle pop credit, so a full queue rejects the push even if it pops that cycle.
- Priority per rising edge: (1) D_stall, (2) D_bubble, (3) normal.
- D_stall=1, with D_bubble ignored:
  - D outputs and D_valid hold.
  - No pop and no flush.
  - An accepted push enqueues at the tail.
- D_bubble=1, D_stall=0:
  - D loads STAT_AOK/ICODE_NOP, all other fields 0, D_valid=0.
  - Queue flushed: count=0, pointers reset.
  - A same-cycle push is dropped (wrong path).
- Normal (D_stall=0, D_bubble=0):
  - count>0: D loads head entry, D_valid=1, head pointer advances. An accepted push enqueues at the tail. Net count is count-1+push.
  - count==0 and push: bypass; D loads f_* directly, D_valid=1, queue stays empty (latency 1 cycle, same as the plain D register).
  - count==0 and no push: D loads bubble (nop fields, D_valid=0).
- FIFO order is strict; pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
- All D outputs are registered; no combinational path from f_* to D_*. f_ready is combinational from the count register only.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with count=3 -> immediately D_stat=8, D_icode=1, D_valid=0, count=0, f_ready=1; after release the first push bypasses to D.
- Bypass: empty queue, no stall, push icode=6 valC=0x10 -> next edge D_icode=6, D_valC=0x10, D_valid=1, count=0.
- Fill under stall: D_stall=1 for 5 cycles with f_valid=1 (icodes 2,3,4,5,7) -> count=4, f_ready=0, the 5th bundle (7) is not accepted, D holds.
- Drain order: release stall with f_valid=0 -> D_icode reads 2,3,4,5 on consecutive edges, then 1 with D_valid=0; count 3,2,1,0.
- Flush: count=3, D_bubble=1, f_valid=1 -> next edge D_icode=1, D_stat=8, D_valid=0, count=0, pushed bundle absent.
- Stall+bubble together with count=2 -> D unchanged, count stays 2 (3 if pushed), no flush.
